// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : reorder_buffer
//  Description : Circular reorder buffer placed directly after dispatch.
//                Allocates one entry per accepted instruction, collects
//                completions from the ALU, memory and branch units, retires
//                in program order (at most one per cycle) and truncates the
//                tail on a branch mispredict, broadcasting a one-cycle flush
//                pulse with the branch tag.
//  Optional    : define ROB_PERF_CNT_EN to add the perf_commits,
//                perf_flushes and perf_full_cycles counter outputs.
//  Ports       : clk, reset (async, active-low)
//                alloc_*      - allocation request from dispatch
//                rob_full     - no free entry
//                rob_index    - index the next allocation receives
//                wb_*         - completion ports (ALU, memory, branch)
//                mispredict*  - registered flush pulse and branch tag
//                commit_*     - head entry retiring this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module reorder_buffer #(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 5,
    parameter int PREG_W = 7,
    parameter int AREG_W = 5
) (
    input  logic              clk,
    input  logic              reset,
`ifdef ROB_PERF_CNT_EN
    output logic [31:0]       perf_commits,
    output logic [15:0]       perf_flushes,
    output logic [31:0]       perf_full_cycles,
`endif
    input  logic              alloc_valid,
    input  logic              alloc_has_dest,
    input  logic [AREG_W-1:0] alloc_rd,
    input  logic [PREG_W-1:0] alloc_pd_new,
    input  logic [PREG_W-1:0] alloc_pd_old,
    output logic              rob_full,
    output logic [IDX_W-1:0]  rob_index,
    input  logic              wb_alu_valid,
    input  logic [IDX_W-1:0]  wb_alu_rob,
    input  logic              wb_mem_valid,
    input  logic [IDX_W-1:0]  wb_mem_rob,
    input  logic              wb_b_valid,
    input  logic [IDX_W-1:0]  wb_b_rob,
    input  logic              wb_b_mispredict,
    output logic              mispredict,
    output logic [IDX_W-1:0]  mispredict_tag,
    output logic              commit_valid,
    output logic              commit_has_dest,
    output logic [AREG_W-1:0] commit_rd,
    output logic [PREG_W-1:0] commit_pd_new,
    output logic [PREG_W-1:0] commit_pd_old
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    // Ring increment that also works for non power-of-two depths.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (int'(p) == DEPTH - 1) return '0;
        return p + PTR_W'(1);
    endfunction

    // Forward distance from base to p around the ring (age relative to head).
    function automatic logic [PTR_W-1:0] ptr_age(input logic [PTR_W-1:0] p,
                                                 input logic [PTR_W-1:0] base);
        if (p >= base) return p - base;
        return PTR_W'(int'(p) + DEPTH - int'(base));
    endfunction

    function automatic logic in_range(input logic [IDX_W-1:0] t);
        return int'(t) < DEPTH;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic [DEPTH-1:0]  valid;
    logic [DEPTH-1:0]  done;
    logic [DEPTH-1:0]  has_dest;
    logic [AREG_W-1:0] rd     [DEPTH];
    logic [PREG_W-1:0] pd_new [DEPTH];
    logic [PREG_W-1:0] pd_old [DEPTH];

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] alu_ptr;
    logic [PTR_W-1:0] mem_ptr;
    logic [PTR_W-1:0] b_ptr;
    logic             alu_hit;
    logic             mem_hit;
    logic             b_hit;
    logic             flush;
    logic             alloc_ok;
    logic [PTR_W-1:0] tag_age;
    logic [DEPTH-1:0] kill;

    assign alu_ptr = wb_alu_rob[PTR_W-1:0];
    assign mem_ptr = wb_mem_rob[PTR_W-1:0];
    assign b_ptr   = wb_b_rob[PTR_W-1:0];

    // Completions only count against live entries.
    assign alu_hit = wb_alu_valid && in_range(wb_alu_rob) && valid[alu_ptr];
    assign mem_hit = wb_mem_valid && in_range(wb_mem_rob) && valid[mem_ptr];
    assign b_hit   = wb_b_valid   && in_range(wb_b_rob)   && valid[b_ptr];

    assign flush    = b_hit && wb_b_mispredict;
    assign alloc_ok = alloc_valid && !rob_full && !flush;
    assign tag_age  = ptr_age(b_ptr, head);

    // An entry is younger than the branch when it sits further from head.
    // Slots beyond the live region are already invalid, so killing them too
    // is harmless and keeps the wrap-around case trivial.
    always_comb begin
        kill = '0;
        for (int i = 0; i < DEPTH; i++) begin
            kill[i] = flush && (ptr_age(PTR_W'(i), head) > tag_age);
        end
    end

    assign commit_valid    = (count != '0) && valid[head] && done[head];
    assign commit_has_dest = has_dest[head];
    assign commit_rd       = rd[head];
    assign commit_pd_new   = pd_new[head];
    assign commit_pd_old   = pd_old[head];

    // Derived from registered state only; no path from alloc_valid.
    assign rob_full  = (count == FULL_COUNT);
    assign rob_index = IDX_W'(tail);

    // ------------------------------------------------------------------
    // Sequential update
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            valid          <= '0;
            done           <= '0;
            has_dest       <= '0;
            mispredict     <= 1'b0;
            mispredict_tag <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd[i]     <= '0;
                pd_new[i] <= '0;
                pd_old[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (commit_valid && head == PTR_W'(i)) valid[i] <= 1'b0;
                if (kill[i])                           valid[i] <= 1'b0;
                // Writebacks to entries being flushed this edge are dropped.
                if (((alu_hit && alu_ptr == PTR_W'(i)) ||
                     (mem_hit && mem_ptr == PTR_W'(i))) && !kill[i]) begin
                    done[i] <= 1'b1;
                end
                if (b_hit && b_ptr == PTR_W'(i)) done[i] <= 1'b1;
                // The tail slot is never live, so allocation cannot collide
                // with a commit or writeback on the same index.
                if (alloc_ok && tail == PTR_W'(i)) begin
                    valid[i]    <= 1'b1;
                    done[i]     <= 1'b0;
                    has_dest[i] <= alloc_has_dest;
                    rd[i]       <= alloc_rd;
                    pd_new[i]   <= alloc_pd_new;
                    pd_old[i]   <= alloc_pd_old;
                end
            end

            if (commit_valid) head <= ptr_inc(head);

            if (flush) begin
                tail  <= ptr_inc(b_ptr);
                count <= CNT_W'(tag_age) + CNT_W'(1) - CNT_W'(commit_valid);
            end else begin
                if (alloc_ok) tail <= ptr_inc(tail);
                count <= count + CNT_W'(alloc_ok) - CNT_W'(commit_valid);
            end

            mispredict     <= flush;
            mispredict_tag <= flush ? wb_b_rob : '0;
        end
    end

`ifdef ROB_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_commits     <= '0;
            perf_flushes     <= '0;
            perf_full_cycles <= '0;
        end else begin
            perf_commits     <= perf_commits     + 32'(commit_valid);
            perf_flushes     <= perf_flushes     + 16'(flush);
            perf_full_cycles <= perf_full_cycles + 32'(rob_full);
        end
    end
`endif

endmodule
`default_nettype wire
